// File: rtl/bt_stream_framer_pkg.sv
// Shared definitions for the sensor-to-Bluetooth framer: state and byte-phase
// encodings, the default sync byte and the byte-index width helper.
package bt_stream_framer_pkg;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_WAIT_LINK = 4'd1,
        S_COLLECT   = 4'd2,
        S_LOAD      = 4'd3,
        S_WAIT_TX   = 4'd4,
        S_GAP       = 4'd5,
        S_FINISH    = 4'd6
    } state_t;

    typedef enum logic [1:0] {
        P_SYNC = 2'd0,
        P_HDR  = 2'd1,
        P_DATA = 2'd2,
        P_CHK  = 2'd3
    } phase_t;

    localparam logic [7:0] DEF_SYNC_BYTE = 8'h7E;

    function automatic int byte_idx_w(input int data_w);
        return ((data_w / 8) > 1) ? $clog2(data_w / 8) : 1;
    endfunction

endpackage

// File: rtl/bt_stream_framer_gap_timer.sv
// Loadable down-counter with a zero flag; shared between the inter-byte gap
// and the tx_done timeout.
module bt_gap_timer #(
    parameter int W = 16
) (
    input  logic         i_clock,
    input  logic         i_reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    // Count down to zero and hold there until reloaded
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_count <= {W{1'b0}};
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != {W{1'b0}}) begin
            r_count <= r_count - W'(1);
        end else begin
            r_count <= r_count;
        end
    end

    assign o_zero = (r_count == {W{1'b0}});

endmodule

// File: rtl/bt_stream_framer.sv
// Snapshots mask-selected sensor words and streams them to a byte-wide UART
// as SYNC, header, data (MSB first) and an XOR checksum, gated by the HC-05 link.
module bt_stream_framer
    import bt_stream_framer_pkg::*;
#(
    parameter int         NUM_STREAMS    = 4,
    parameter int         DATA_W         = 16,
    parameter int         GAP_CYCLES     = 385,
    parameter int         TIMEOUT_CYCLES = 4095,
    parameter logic [7:0] SYNC_BYTE      = DEF_SYNC_BYTE,
    parameter int         CNT_W          = 16
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    input  logic                          i_enable,
    input  logic [NUM_STREAMS-1:0]        i_stream_mask,
    input  logic [NUM_STREAMS*DATA_W-1:0] i_stream_data,
    input  logic [NUM_STREAMS-1:0]        i_stream_valid,
    output logic [NUM_STREAMS-1:0]        o_stream_ack,
    input  logic                          i_bt_state,
    output logic                          o_tx_start,
    output logic [7:0]                    o_tx_data,
    input  logic                          i_tx_done,
    output logic                          o_busy,
    output logic                          o_frame_abort,
    output logic [CNT_W-1:0]              o_frame_count,
    output logic [3:0]                    o_state_dbg
);

    localparam int NB      = DATA_W / 8;
    localparam int BIDX_W  = byte_idx_w(DATA_W);
    localparam int TMR_MAX = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    state_t                        r_state, w_next_state;
    phase_t                        r_phase, w_next_phase;
    logic [3:0]                    r_stream, w_next_stream, w_scan_from;
    logic [BIDX_W-1:0]             r_bidx, w_next_bidx;
    logic [NUM_STREAMS-1:0]        r_mask, r_ack;
    logic [NUM_STREAMS*DATA_W-1:0] r_snap, w_cap_data;
    logic [7:0]                    r_chk, r_tx_data, w_next_byte;
    logic                          r_tx_start, r_busy, r_abort;
    logic [CNT_W-1:0]              r_frame_count;
    logic                          w_capture, w_advance, w_abort, w_finish;
    logic                          w_tmr_load, w_tmr_zero;
    logic [TMR_W-1:0]              w_tmr_val;

    // Lowest enabled stream at or above 'from'; NUM_STREAMS when none remain
    function automatic logic [3:0] f_next_stream(input logic [NUM_STREAMS-1:0] m,
                                                 input logic [3:0] from);
        logic [3:0] idx;
        idx = 4'(NUM_STREAMS);
        for (int i = NUM_STREAMS - 1; i >= 0; i--) begin
            if (m[i] && (4'(i) >= from)) idx = 4'(i);
        end
        return idx;
    endfunction

    function automatic logic [7:0] f_pick(input logic [NUM_STREAMS*DATA_W-1:0] snap,
                                          input logic [3:0] idx,
                                          input logic [BIDX_W-1:0] bidx);
        logic [DATA_W-1:0] word;
        logic [7:0]        b;
        word = {DATA_W{1'b0}};
        b    = 8'h00;
        for (int i = 0; i < NUM_STREAMS; i++) begin
            if (4'(i) == idx) word = snap[i*DATA_W +: DATA_W];
        end
        for (int k = 0; k < NB; k++) begin
            if (BIDX_W'(k) == bidx) b = word[(NB-1-k)*8 +: 8];
        end
        return b;
    endfunction

    // Checksum covers the header and every data byte, not the sync byte
    function automatic logic [7:0] f_chk(input logic [NUM_STREAMS-1:0] m,
                                         input logic [NUM_STREAMS*DATA_W-1:0] d);
        logic [7:0] c;
        c = 8'(m);
        for (int i = 0; i < NUM_STREAMS; i++) begin
            for (int k = 0; k < NB; k++) begin
                if (m[i]) c = c ^ d[i*DATA_W + k*8 +: 8];
            end
        end
        return c;
    endfunction

    bt_gap_timer #(.W(TMR_W)) u_timer (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_zero     (w_tmr_zero)
    );

    // Masked capture of the incoming words; disabled streams snapshot as zero
    always_comb begin
        w_cap_data = {(NUM_STREAMS*DATA_W){1'b0}};
        for (int i = 0; i < NUM_STREAMS; i++) begin
            if (i_stream_mask[i]) begin
                w_cap_data[i*DATA_W +: DATA_W] = i_stream_data[i*DATA_W +: DATA_W];
            end else begin
                w_cap_data[i*DATA_W +: DATA_W] = {DATA_W{1'b0}};
            end
        end
    end

    // Next byte of the frame and the cursor that points at it
    always_comb begin
        w_next_phase  = r_phase;
        w_next_stream = r_stream;
        w_next_bidx   = r_bidx;
        w_next_byte   = r_tx_data;
        w_scan_from   = 4'd0;
        case (r_phase)
            P_SYNC: begin
                w_next_phase = P_HDR;
                w_next_byte  = 8'(r_mask);
            end
            P_HDR, P_DATA: begin
                if ((r_phase == P_DATA) && (r_bidx != BIDX_W'(NB - 1))) begin
                    w_next_bidx = r_bidx + BIDX_W'(1);
                end else begin
                    w_next_bidx   = {BIDX_W{1'b0}};
                    w_scan_from   = (r_phase == P_HDR) ? 4'd0 : (r_stream + 4'd1);
                    w_next_stream = f_next_stream(r_mask, w_scan_from);
                end
                if (w_next_stream < 4'(NUM_STREAMS)) begin
                    w_next_phase = P_DATA;
                    w_next_byte  = f_pick(r_snap, w_next_stream, w_next_bidx);
                end else begin
                    w_next_phase = P_CHK;
                    w_next_byte  = r_chk;
                end
            end
            default: begin
                w_next_phase = r_phase;
            end
        endcase
    end

    // Frame sequencing; the timer is loaded on entry to WAIT_TX and GAP
    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        w_advance    = 1'b0;
        w_abort      = 1'b0;
        w_finish     = 1'b0;
        w_tmr_load   = 1'b0;
        w_tmr_val    = {TMR_W{1'b0}};
        case (r_state)
            S_IDLE: begin
                if (i_enable) w_next_state = S_WAIT_LINK;
                else          w_next_state = S_IDLE;
            end
            S_WAIT_LINK: begin
                if (i_bt_state)     w_next_state = S_COLLECT;
                else if (!i_enable) w_next_state = S_IDLE;
                else                w_next_state = S_WAIT_LINK;
            end
            S_COLLECT: begin
                if ((i_stream_valid & i_stream_mask) == i_stream_mask) begin
                    w_capture    = 1'b1;
                    w_next_state = S_LOAD;
                end else begin
                    w_next_state = S_COLLECT;
                end
            end
            S_LOAD: begin
                w_next_state = S_WAIT_TX;
                w_tmr_load   = 1'b1;
                w_tmr_val    = TMR_W'(TIMEOUT_CYCLES - 2);
            end
            S_WAIT_TX: begin
                if (i_tx_done) begin
                    w_next_state = S_GAP;
                    w_tmr_load   = 1'b1;
                    w_tmr_val    = TMR_W'(GAP_CYCLES - 1);
                end else if (w_tmr_zero) begin
                    w_abort      = 1'b1;
                    w_next_state = S_WAIT_LINK;
                end else begin
                    w_next_state = S_WAIT_TX;
                end
            end
            S_GAP: begin
                if (!w_tmr_zero) begin
                    w_next_state = S_GAP;
                end else if (r_phase == P_CHK) begin
                    w_next_state = S_FINISH;
                end else if (!i_bt_state) begin
                    w_abort      = 1'b1;
                    w_next_state = S_WAIT_LINK;
                end else begin
                    w_advance    = 1'b1;
                    w_next_state = S_LOAD;
                end
            end
            S_FINISH: begin
                w_finish = 1'b1;
                if (i_enable && i_bt_state) w_next_state = S_COLLECT;
                else                        w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // State, snapshot, byte cursor and registered outputs
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_phase       <= P_SYNC;
            r_stream      <= 4'd0;
            r_bidx        <= {BIDX_W{1'b0}};
            r_mask        <= {NUM_STREAMS{1'b0}};
            r_ack         <= {NUM_STREAMS{1'b0}};
            r_snap        <= {(NUM_STREAMS*DATA_W){1'b0}};
            r_chk         <= 8'h00;
            r_tx_data     <= 8'h00;
            r_tx_start    <= 1'b0;
            r_busy        <= 1'b0;
            r_abort       <= 1'b0;
            r_frame_count <= {CNT_W{1'b0}};
        end else begin
            r_state    <= w_next_state;
            r_tx_start <= (w_next_state == S_LOAD);
            r_busy     <= (w_next_state != S_IDLE);
            r_abort    <= w_abort;
            r_ack      <= w_capture ? i_stream_mask : {NUM_STREAMS{1'b0}};
            if (w_capture) begin
                r_mask    <= i_stream_mask;
                r_snap    <= w_cap_data;
                r_chk     <= f_chk(i_stream_mask, w_cap_data);
                r_phase   <= P_SYNC;
                r_stream  <= 4'd0;
                r_bidx    <= {BIDX_W{1'b0}};
                r_tx_data <= SYNC_BYTE;
            end else if (w_advance) begin
                r_phase   <= w_next_phase;
                r_stream  <= w_next_stream;
                r_bidx    <= w_next_bidx;
                r_tx_data <= w_next_byte;
            end else if (w_abort) begin
                r_mask  <= {NUM_STREAMS{1'b0}};
                r_snap  <= {(NUM_STREAMS*DATA_W){1'b0}};
                r_chk   <= 8'h00;
                r_phase <= P_SYNC;
            end
            if (w_finish) r_frame_count <= r_frame_count + CNT_W'(1);
        end
    end

    assign o_stream_ack  = r_ack;
    assign o_tx_start    = r_tx_start;
    assign o_tx_data     = r_tx_data;
    assign o_busy        = r_busy;
    assign o_frame_abort = r_abort;
    assign o_frame_count = r_frame_count;
    assign o_state_dbg   = r_state;

endmodule

// File: tb/tb_bt_stream_framer.sv
// Directed plus randomized bench for bt_stream_framer; a UART model answers
// every byte 20 cycles after tx_start and a frame model predicts the byte stream.
module tb_bt_stream_framer;

    localparam int GAP = 385;
    localparam int TMO = 4095;
    localparam int CW  = 4;

    logic          clk = 1'b0;
    logic          rst, en, bt, tx_done;
    logic [3:0]    mask, valid, ack, sdbg;
    logic [63:0]   data;
    logic          tx_start, busy, abort;
    logic [7:0]    tx_data;
    logic [CW-1:0] fcount;

    int         cyc = 0;
    int         n_tests = 0;
    int         n_fail = 0;
    int         model_count = 0;
    bit         withhold = 1'b0;
    logic [7:0] bytes_q[$];
    int         start_q[$];
    int         done_q[$];
    int         abort_q[$];
    logic [3:0] ack_q[$];

    bt_stream_framer #(.CNT_W(CW)) dut (
        .i_clock       (clk),
        .i_reset       (rst),
        .i_enable      (en),
        .i_stream_mask (mask),
        .i_stream_data (data),
        .i_stream_valid(valid),
        .o_stream_ack  (ack),
        .i_bt_state    (bt),
        .o_tx_start    (tx_start),
        .o_tx_data     (tx_data),
        .i_tx_done     (tx_done),
        .o_busy        (busy),
        .o_frame_abort (abort),
        .o_frame_count (fcount),
        .o_state_dbg   (sdbg)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // UART_tx stand-in: logs each byte and returns tx_done 20 cycles later
    initial begin
        tx_done = 1'b0;
        forever begin
            @(posedge clk); #1;
            tx_done = 1'b0;
            if (tx_start === 1'b1) begin
                bytes_q.push_back(tx_data);
                start_q.push_back(cyc);
                if (!withhold) begin
                    repeat (20) @(posedge clk);
                    #1;
                    tx_done = 1'b1;
                    done_q.push_back(cyc);
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if ((|ack) === 1'b1) ack_q.push_back(ack);
            if (abort === 1'b1) abort_q.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        bytes_q.delete(); start_q.delete(); done_q.delete(); abort_q.delete(); ack_q.delete();
    endtask

    task automatic wait_state(input string tag, input logic [3:0] s, input int limit);
        int n = 0;
        while (sdbg !== s && n < limit) begin tick(); n++; end
        chk(tag, 64'(sdbg), 64'(s));
    endtask

    task automatic wait_starts(input string tag, input int cnt, input int limit);
        int n = 0;
        while (start_q.size() < cnt && n < limit) begin tick(); n++; end
        chk(tag, 64'(start_q.size() >= cnt), 64'd1);
    endtask

    task automatic wait_count(input string tag, input int v, input int limit);
        int n = 0;
        while (int'(fcount) != v && n < limit) begin tick(); n++; end
        chk(tag, 64'(fcount), 64'(v));
    endtask

    // One complete frame: build the expected byte list from the framing rules
    task automatic do_frame(input string tag, input logic [3:0] m, input logic [63:0] words);
        logic [7:0] exp_q[$];
        logic [7:0] c, hi, lo, ob;
        clear_logs();
        exp_q.push_back(8'h7E);
        exp_q.push_back({4'h0, m});
        c = {4'h0, m};
        for (int i = 0; i < 4; i++) begin
            if (m[i]) begin
                hi = words[i*16+8 +: 8];
                lo = words[i*16 +: 8];
                exp_q.push_back(hi);
                exp_q.push_back(lo);
                c = c ^ hi ^ lo;
            end
        end
        exp_q.push_back(c);
        mask = m; data = words; bt = 1'b1; en = 1'b1;
        valid = ~m;
        if (m != 4'h0) begin
            repeat (12) tick();
            chk({tag, "_hold_state"}, 64'(sdbg), 64'd2);
            chk({tag, "_hold_ack"}, 64'(ack_q.size()), 64'd0);
        end
        valid = 4'hF;
        wait_starts({tag, "_start"}, 1, 50);
        en = 1'b0;
        mask = ~m;
        data = {$urandom, $urandom};
        wait_state({tag, "_idle"}, 4'd0, 20000);
        chk({tag, "_nbytes"}, 64'(bytes_q.size()), 64'(exp_q.size()));
        for (int k = 0; k < exp_q.size(); k++) begin
            ob = 'x;
            if (k < bytes_q.size()) ob = bytes_q[k];
            chk($sformatf("%s_byte%0d", tag, k), 64'(ob), 64'(exp_q[k]));
        end
        for (int k = 1; k < start_q.size(); k++) begin
            if (k - 1 < done_q.size())
                chk($sformatf("%s_gap%0d", tag, k), 64'(start_q[k] - done_q[k-1]), 64'(GAP + 1));
        end
        chk({tag, "_nack"}, 64'(ack_q.size()), 64'(m != 4'h0));
        if (ack_q.size() > 0) chk({tag, "_ack"}, 64'(ack_q[0]), 64'(m));
        model_count = (model_count + 1) % (1 << CW);
        chk({tag, "_count"}, 64'(fcount), 64'(model_count));
    endtask

    initial begin
        logic [63:0] words;
        logic [3:0]  rm;
        int          base;
        rst = 1'b1; en = 1'b0; bt = 1'b0; mask = 4'h0; valid = 4'h0; data = 64'h0;
        repeat (3) tick();
        chk("rst_tx_start", 64'(tx_start), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_abort", 64'(abort), 64'd0);
        chk("rst_count", 64'(fcount), 64'd0);
        chk("rst_state", 64'(sdbg), 64'd0);
        chk("rst_tx_data", 64'(tx_data), 64'd0);
        chk("rst_ack", 64'(ack), 64'd0);
        rst = 1'b0;
        tick();

        words = {16'h3B29, 16'h6E49, 16'h5B5D, 16'h4869};
        do_frame("t1", 4'b0101, words);
        chk("t1_chk_lit", 64'((bytes_q.size() > 0) ? bytes_q[bytes_q.size()-1] : 8'hxx), 64'h03);
        do_frame("t2", 4'b1111, words);
        chk("t2_chk_lit", 64'((bytes_q.size() > 0) ? bytes_q[bytes_q.size()-1] : 8'hxx), 64'h1D);

        // Heartbeats back to back while enable stays high
        clear_logs();
        mask = 4'h0; bt = 1'b1; en = 1'b1;
        base = model_count;
        wait_count("t3_count2", (base + 2) % (1 << CW), 5000);
        en = 1'b0;
        wait_state("t3_idle", 4'd0, 3000);
        model_count = (base + 3) % (1 << CW);
        chk("t3_count3", 64'(fcount), 64'(model_count));
        chk("t3_nbytes", 64'(bytes_q.size()), 64'd9);
        for (int k = 0; k < 9 && k < bytes_q.size(); k++)
            chk($sformatf("t3_byte%0d", k), 64'(bytes_q[k]), (k % 3 == 0) ? 64'h7E : 64'h00);

        for (int r = 0; r < 3; r++) begin
            rm = 4'($urandom_range(1, 15));
            words = {$urandom, $urandom};
            do_frame($sformatf("rnd%0d", r), rm, words);
        end

        // Link loss while byte 3 is on the wire
        clear_logs();
        mask = 4'b0101; data = {16'h3B29, 16'h6E49, 16'h5B5D, 16'h4869};
        valid = 4'hF; bt = 1'b1; en = 1'b1;
        wait_starts("t4_third", 3, 5000);
        bt = 1'b0;
        begin
            int n = 0;
            while (abort_q.size() == 0 && n < 2000) begin tick(); n++; end
        end
        chk("t4_abort_seen", 64'(abort_q.size()), 64'd1);
        repeat (5) tick();
        chk("t4_state", 64'(sdbg), 64'd1);
        if (abort_q.size() > 0 && done_q.size() > 2)
            chk("t4_abort_time", 64'(abort_q[0] - done_q[2]), 64'(GAP + 1));
        repeat (500) tick();
        chk("t4_nbytes", 64'(bytes_q.size()), 64'd3);
        chk("t4_count", 64'(fcount), 64'(model_count));
        en = 1'b0;
        repeat (3) tick();
        chk("t4_idle", 64'(sdbg), 64'd0);

        // tx_done never returns
        clear_logs();
        withhold = 1'b1;
        mask = 4'h0; bt = 1'b1; en = 1'b1;
        wait_starts("t5_start", 1, 50);
        begin
            int n = 0;
            while (abort !== 1'b1 && n < 5000) begin tick(); n++; end
        end
        chk("t5_abort", 64'(abort), 64'd1);
        chk("t5_state", 64'(sdbg), 64'd1);
        bt = 1'b0; en = 1'b0;
        tick();
        withhold = 1'b0;
        chk("t5_idle", 64'(sdbg), 64'd0);
        if (abort_q.size() > 0 && start_q.size() > 0)
            chk("t5_abort_time", 64'(abort_q[0] - start_q[0]), 64'(TMO));
        chk("t5_count", 64'(fcount), 64'(model_count));

        // Reset in the middle of an inter-byte gap
        clear_logs();
        mask = 4'h0; bt = 1'b1; en = 1'b1;
        begin
            int n = 0;
            while (done_q.size() == 0 && n < 200) begin tick(); n++; end
        end
        repeat (100) tick();
        chk("t6_in_gap", 64'(sdbg), 64'd5);
        rst = 1'b1;
        tick();
        chk("t6_state", 64'(sdbg), 64'd0);
        chk("t6_busy", 64'(busy), 64'd0);
        chk("t6_tx_start", 64'(tx_start), 64'd0);
        chk("t6_tx_data", 64'(tx_data), 64'd0);
        chk("t6_count", 64'(fcount), 64'd0);
        chk("t6_ack", 64'(ack), 64'd0);
        rst = 1'b0; en = 1'b0;
        repeat (3) tick();
        chk("t6_no_abort", 64'(abort_q.size()), 64'd0);
        model_count = 0;

        // Counter wrap from all-ones back to zero
        clear_logs();
        mask = 4'h0; bt = 1'b1; en = 1'b1;
        wait_count("wrap_top", (1 << CW) - 1, 25000);
        en = 1'b0;
        wait_state("wrap_idle", 4'd0, 3000);
        chk("wrap_count", 64'(fcount), 64'd0);
        chk("wrap_nbytes", 64'(bytes_q.size()), 64'(3 * (1 << CW)));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
